// File: rtl/clk_switch_ctrl.sv
// Break-before-make sequencer for the glitch-free clock switch enables.
// Drops the active enable, waits DLY cycles, raises the target, holds it DLY cycles.
module clk_switch_ctrl #(
    parameter int unsigned DLY     = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter bit          RST_SEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sel_req,
    input  logic clk0_ok,
    input  logic clk1_ok,
    output logic sel_clk0_dly3,
    output logic sel_clk1_dly3,
    output logic cur_sel,
    output logic busy,
    output logic switch_done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_OK = 3'd1,
        OFF     = 3'd2,
        ON      = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0] DLY_LAST = 4'(DLY - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    logic [1:0] ok0_sync_q;
    logic [1:0] ok1_sync_q;
    logic       tgt_ok;

    state_t     state_q;
    logic [3:0] dly_cnt_q;
    logic [7:0] to_cnt_q;
    logic       en0_q;
    logic       en1_q;
    logic       cur_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ok0_sync_q <= 2'b00;
            ok1_sync_q <= 2'b00;
        end else begin
            ok0_sync_q <= {ok0_sync_q[0], clk0_ok};
            ok1_sync_q <= {ok1_sync_q[0], clk1_ok};
        end
    end

    // The target is always the source not currently committed.
    assign tgt_ok = cur_q ? ok0_sync_q[1] : ok1_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dly_cnt_q <= 4'd0;
            to_cnt_q  <= 8'd0;
            en0_q     <= ~RST_SEL;
            en1_q     <= RST_SEL;
            cur_q     <= RST_SEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_req != cur_q) begin
                        if (!err_q) begin
                            state_q  <= WAIT_OK;
                            busy_q   <= 1'b1;
                            to_cnt_q <= 8'd0;
                        end
                    end else begin
                        err_q <= 1'b0;
                    end
                end
                WAIT_OK: begin
                    if (tgt_ok) begin
                        state_q   <= OFF;
                        en0_q     <= 1'b0;
                        en1_q     <= 1'b0;
                        dly_cnt_q <= 4'd0;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end
                OFF: begin
                    if (dly_cnt_q == DLY_LAST) begin
                        state_q   <= ON;
                        en0_q     <= cur_q;
                        en1_q     <= ~cur_q;
                        cur_q     <= ~cur_q;
                        dly_cnt_q <= 4'd0;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 4'd1;
                    end
                end
                ON: begin
                    if (dly_cnt_q == DLY_LAST) begin
                        state_q <= DONE;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel_clk0_dly3 = en0_q;
    assign sel_clk1_dly3 = en1_q;
    assign cur_sel       = cur_q;
    assign busy          = busy_q;
    assign switch_done   = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench: a timeline model predicts completion/timeout events, a monitor checks them.
module tb_clk_switch_ctrl;

    localparam int DLY     = 3;
    localparam int TIMEOUT = 8;
    localparam bit RST_SEL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel_req = 1'b0;
    logic clk0_ok = 1'b0;
    logic clk1_ok = 1'b0;
    logic sel_clk0_dly3, sel_clk1_dly3, cur_sel, busy, switch_done, err;

    clk_switch_ctrl #(.DLY(DLY), .TIMEOUT(TIMEOUT), .RST_SEL(RST_SEL)) dut (
        .clk(clk), .rst(rst), .sel_req(sel_req), .clk0_ok(clk0_ok), .clk1_ok(clk1_ok),
        .sel_clk0_dly3(sel_clk0_dly3), .sel_clk1_dly3(sel_clk1_dly3), .cur_sel(cur_sel),
        .busy(busy), .switch_done(switch_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    typedef struct { bit is_done; int at; bit tgt; } ev_t;
    ev_t expq[$];

    // Reference model: outcome of each request expressed as absolute cycle arithmetic.
    bit raw0 [0:19999];
    bit raw1 [0:19999];
    int last_rst = 0;
    int m_phase = 0;   // 0 sampling requests, 1 waiting for ok, 2 switching
    int m_wstart = 0;
    int m_end = 0;
    bit m_cur = RST_SEL;
    bit m_err = 1'b0;
    bit m_tgt = 1'b0;

    function automatic bit ok_seen(input bit which, input int c);
        if (c - 2 <= last_rst) return 1'b0;
        return which ? raw1[c-2] : raw0[c-2];
    endfunction

    always @(negedge clk) begin
        raw0[cyc] = clk0_ok;
        raw1[cyc] = clk1_ok;
        if (rst) begin
            m_phase = 0;
            m_cur = RST_SEL;
            m_err = 1'b0;
            last_rst = cyc;
            while (expq.size() > 0 && expq[$].at > cyc) void'(expq.pop_back());
        end else begin
            case (m_phase)
                0: begin
                    if (sel_req != m_cur) begin
                        if (!m_err) begin
                            m_phase = 1;
                            m_wstart = cyc + 1;
                            m_tgt = !m_cur;
                        end
                    end else begin
                        m_err = 1'b0;
                    end
                end
                1: begin
                    if (ok_seen(m_tgt, cyc)) begin
                        m_end = cyc + 2 + 2 * DLY;
                        expq.push_back('{1'b1, m_end, m_tgt});
                        m_cur = m_tgt;
                        m_phase = 2;
                    end else if (cyc - m_wstart == TIMEOUT - 1) begin
                        m_err = 1'b1;
                        expq.push_back('{1'b0, cyc + 1, m_cur});
                        m_phase = 0;
                    end
                end
                default: begin
                    if (cyc + 1 == m_end) m_phase = 0;
                end
            endcase
        end
    end

    // Monitor
    bit mon_on = 1'b0;
    bit err_prev = 1'b0;
    int gap = 0;
    int last_gap = -1;
    int both_hi = 0;

    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            if (sel_clk0_dly3 && sel_clk1_dly3) both_hi++;
            if (!sel_clk0_dly3 && !sel_clk1_dly3) gap++;
            else if (gap > 0) begin
                last_gap = gap;
                gap = 0;
            end
            while (expq.size() > 0 && expq[0].at < cyc) begin
                e = expq.pop_front();
                check("missed_event_cycle", cyc, e.at);
            end
            if (switch_done) begin
                if (expq.size() == 0) check("unexpected_switch_done", 1, 0);
                else begin
                    e = expq.pop_front();
                    check("done_is_switch", 1, int'(e.is_done));
                    check("done_cycle", cyc, e.at);
                    check("done_cur_sel", int'(cur_sel), int'(e.tgt));
                    check("done_both_low_gap", last_gap, DLY);
                    check("done_busy", int'(busy), 0);
                end
            end
            if (err && !err_prev) begin
                if (expq.size() == 0) check("unexpected_err", 1, 0);
                else begin
                    e = expq.pop_front();
                    check("err_is_timeout", 0, int'(e.is_done));
                    check("err_cycle", cyc, e.at);
                    check("err_busy", int'(busy), 0);
                    check("err_enables", int'({sel_clk1_dly3, sel_clk0_dly3}), e.tgt ? 2 : 1);
                end
            end
            err_prev = err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit sig(input int w);
        case (w)
            0: return sel_clk0_dly3;
            1: return sel_clk1_dly3;
            2: return switch_done;
            default: return !sel_clk0_dly3 && !sel_clk1_dly3;
        endcase
    endfunction

    task automatic wait_sig(input int which, input bit val, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig(which) == val) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check($sformatf("wait_timeout_sig%0d", which), 0, 1);
    endtask

    initial begin
        int r, at, nb;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        mon_on = 1'b1;

        // Reset state held while the request matches.
        for (int i = 0; i < 4; i++) begin
            tick(5);
            @(negedge clk);
            check("rst_en0", int'(sel_clk0_dly3), 1);
            check("rst_en1", int'(sel_clk1_dly3), 0);
            check("rst_cur_sel", int'(cur_sel), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_err", int'(err), 0);
        end

        // Timeout with clk1 never ready.
        tick(1);
        sel_req = 1'b1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (err) break;
        end
        check("timeout_busy_cycles", nb, TIMEOUT);
        check("timeout_err", int'(err), 1);
        tick(5);
        @(negedge clk);
        check("err_blocks_retry", int'(busy), 0);
        check("err_sticky", int'(err), 1);
        tick(1);
        sel_req = 1'b0;
        tick(2);
        @(negedge clk);
        check("err_cleared", int'(err), 0);

        // Clean switch to clk1 with ok already synchronized.
        tick(1);
        clk1_ok = 1'b1;
        tick(4);
        sel_req = 1'b1;
        r = cyc;
        wait_sig(0, 1'b0, 40, at);
        check("old_enable_low_cycle", at - r, 2);
        wait_sig(1, 1'b1, 40, at);
        check("new_enable_high_cycle", at - r, 2 + DLY);
        wait_sig(2, 1'b1, 40, at);
        check("switch_done_cycle", at - r, 3 + 2 * DLY);
        check("switched_cur_sel", int'(cur_sel), 1);

        // Request reverts mid-sequence: finish, then switch straight back.
        tick(2);
        clk0_ok = 1'b1;
        tick(4);
        sel_req = 1'b0;
        wait_sig(3, 1'b1, 40, at);
        tick(1);
        sel_req = 1'b1;
        wait_sig(2, 1'b1, 60, at);
        check("revert_first_done_cur", int'(cur_sel), 0);
        wait_sig(2, 1'b1, 60, at);
        check("revert_second_done_cur", int'(cur_sel), 1);

        // Reset while both enables are low.
        tick(2);
        sel_req = 1'b0;
        wait_sig(3, 1'b1, 40, at);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_en0", int'(sel_clk0_dly3), 1);
        check("mid_rst_en1", int'(sel_clk1_dly3), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cur_sel", int'(cur_sel), 0);

        // Random request / ready / reset activity.
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if ($urandom_range(24) == 0) sel_req = !sel_req;
            if ($urandom_range(39) == 0) clk0_ok = !clk0_ok;
            if ($urandom_range(39) == 0) clk1_ok = !clk1_ok;
            rst = ($urandom_range(1499) == 0);
        end
        rst = 1'b0;
        clk0_ok = 1'b1;
        clk1_ok = 1'b1;
        tick(100);
        @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        check("both_enables_high_cycles", both_hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
